// File: rtl/muldiv_unit_if.sv
// Handshake and result bus between the MIPS control/datapath and the
// iterative multiply/divide unit that owns HI/LO.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] Read_A;
  logic [WIDTH-1:0] Read_B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, Read_A, Read_B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, Read_A, Read_B,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider owning HI/LO.
// Signed ops run on magnitudes; signs are applied in a final SIGN cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;

  logic [1:0]       state;
  logic [5:0]       cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_acc;
  logic [WIDTH-1:0] lo_acc;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic               ge;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.HI   = hi_r;
  assign bus.LO   = lo_r;

  always_comb begin
    mag_a = (bus.op[0] && bus.Read_A[WIDTH-1]) ? -bus.Read_A : bus.Read_A;
    mag_b = (bus.op[0] && bus.Read_B[WIDTH-1]) ? -bus.Read_B : bus.Read_B;
  end

  // Multiply shifts {hi_acc,lo_acc} right with the adder carry entering at the top;
  // divide shifts left, rem in hi_acc and the quotient filling lo_acc from the LSB.
  always_comb begin
    sum     = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);
    sh      = {hi_acc, lo_acc[WIDTH-1]};
    ge      = (sh >= {1'b0, opnd});
    step_hi = '0;
    step_lo = '0;
    if (is_div) begin
      step_hi = ge ? (sh[WIDTH-1:0] - opnd) : sh[WIDTH-1:0];
      step_lo = {lo_acc[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {hi_acc, lo_acc};
    res_hi = '0;
    res_lo = '0;
    if (!is_div) begin
      if (neg_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (dz) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? -hi_acc : hi_acc;
      res_lo = neg_q ? -lo_acc : lo_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      hi_acc <= '0;
      lo_acc <= '0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              is_div <= bus.op[1];
              neg_q  <= bus.op[0] & (bus.Read_A[WIDTH-1] ^ bus.Read_B[WIDTH-1]);
              neg_r  <= bus.op[0] & bus.Read_A[WIDTH-1];
              dz     <= bus.op[1] & (bus.Read_B == '0);
              a_raw  <= bus.Read_A;
              hi_acc <= '0;
              lo_acc <= bus.op[1] ? mag_a : mag_b;
              opnd   <= bus.op[1] ? mag_b : mag_a;
              cnt    <= '0;
              state  <= CALC;
            end else if (bus.op == 3'b100) begin
              hi_r <= bus.Read_A;
            end else if (bus.op == 3'b101) begin
              lo_r <= bus.Read_A;
            end
          end
        end
        CALC: begin
          hi_acc <= step_hi;
          lo_acc <= step_lo;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= SIGN;
        end
        SIGN: begin
          hi_r   <= res_hi;
          lo_r   <= res_lo;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random ops checked
// against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO} as the architecture defines the result.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        u = {32'h0, a} * {32'h0, b};
        return u;
      end
      3'd1: begin
        p = sa * sb;
        return p;
      end
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done should be high,
  // so a following call starts back-to-back in the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stray);
    logic [63:0] m;
    int n;
    m = model(op, a, b);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.Read_A = a;
    bus.Read_B = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (n == 1) check({tag, "_done_low"}, 32'(bus.done), 32'd0);
      if (n == 10) begin
        check({tag, "_hold_hi"}, bus.HI, exp_hi);
        check({tag, "_hold_lo"}, bus.LO, exp_lo);
      end
      bus.Read_A = $urandom;
      bus.Read_B = $urandom;
      bus.op     = 3'($urandom_range(0, 7));
      bus.start  = (n == stray);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    exp_hi = m[63:32];
    exp_lo = m[31:0];
    check({tag, "_hi"}, bus.HI, exp_hi);
    check({tag, "_lo"}, bus.LO, exp_lo);
  endtask

  initial begin
    int seen;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.Read_A = '0;
    bus.Read_B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_max_hi_lit", bus.HI, 32'hFFFF_FFFE);
    run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7, -1);
    check("mult_neg_lo_lit", bus.LO, 32'hFFFF_FFEB);
    run_op("multu_same", 3'd0, 32'hFFFF_FFFD, 32'd7, -1);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_neg_lo_lit", bus.LO, 32'hFFFF_FFFD);
    run_op("divu", 3'd2, 32'd100, 32'd7, -1);
    run_op("divu_zero", 3'd2, 32'h1234, 32'd0, -1);
    run_op("div_zero", 3'd3, 32'hFFFF_FF00, 32'd0, -1);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_lo_lit", bus.LO, 32'h8000_0000);

    bus.start  = 1'b1;
    bus.op     = 3'd4;
    bus.Read_A = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_hi", bus.HI, 32'hDEAD_BEEF);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    check("mthi_done", 32'(bus.done), 32'd0);
    bus.op     = 3'd5;
    bus.Read_A = 32'h0BAD_F00D;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo", bus.LO, 32'h0BAD_F00D);
    check("mtlo_hi", bus.HI, 32'hDEAD_BEEF);
    check("mtlo_busy", 32'(bus.busy), 32'd0);
    check("mtlo_done", 32'(bus.done), 32'd0);
    exp_hi = 32'hDEAD_BEEF;
    exp_lo = 32'h0BAD_F00D;

    bus.op = 3'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("noop_busy", 32'(bus.busy), 32'd0);
    check("noop_hi", bus.HI, exp_hi);

    run_op("mult_stray", 3'd1, 32'd12345, 32'hFFFF_FF85, 5);
    check("stray_idle", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 3 == 0) ra = ra | 32'h8000_0000;
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, -1);
    end

    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 3'd2;
    bus.Read_A = 32'd999;
    bus.Read_B = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run_op("multu_6x7", 3'd0, 32'd6, 32'd7, -1);
    check("multu_6x7_lit", bus.LO, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
